// File: rtl/rst_seq16.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq16
// Purpose  : Reset release sequencer for the 16-domain reset synchronizer
//            bank. Holds all domains, releases enabled domains one at a time
//            in index order with a programmable gap, then services per-domain
//            soft-reset pulse requests.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq16 #(
    parameter int HOLD_CYC  = 16,   // cycles all domains held before first release (1..65535)
    parameter int PULSE_CYC = 8     // soft-reset pulse length in cycles (1..255)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] en,
    input  logic [7:0]  gap,
    input  logic [15:0] swrst,
    output logic [15:0] rstmsk,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cur_dom
);

    localparam logic [15:0] c_HOLD_LAST  = 16'(HOLD_CYC - 1);
    localparam logic [15:0] c_PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [3:0]  c_LAST_IDX   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HOLD  = 3'd1,
        S_SCAN  = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_PULSE = 3'd5
    } state_t;

    state_t      r_state,     w_state;
    logic [15:0] r_cnt,       w_cnt;
    logic [3:0]  r_idx,       w_idx;
    logic [15:0] r_en_q,      w_en_q;
    logic [7:0]  r_gap_q,     w_gap_q;
    logic [15:0] r_pending,   w_pending;
    logic [15:0] r_pulse_set, w_pulse_set;
    logic [15:0] r_rstmsk,    w_rstmsk;
    logic        r_busy,      w_busy;
    logic        r_done,      w_done;
    logic [3:0]  r_cur_dom,   w_cur_dom;

    // Only requests for participating domains are ever captured.
    logic [15:0] w_swrst_ok;
    assign w_swrst_ok = swrst & r_en_q;

    // State register plus registered copies of every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            r_idx       <= 4'd0;
            r_en_q      <= 16'd0;
            r_gap_q     <= 8'd0;
            r_pending   <= 16'd0;
            r_pulse_set <= 16'd0;
            r_rstmsk    <= 16'hFFFF;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_dom   <= 4'd0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_en_q      <= w_en_q;
            r_gap_q     <= w_gap_q;
            r_pending   <= w_pending;
            r_pulse_set <= w_pulse_set;
            r_rstmsk    <= w_rstmsk;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_cur_dom   <= w_cur_dom;
        end
    end

    // Next-state, datapath and next-output computation.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_idx       = r_idx;
        w_en_q      = r_en_q;
        w_gap_q     = r_gap_q;
        w_pending   = r_pending;
        w_pulse_set = r_pulse_set;
        w_rstmsk    = r_rstmsk;

        case (r_state)
            S_IDLE: begin
                w_rstmsk = 16'hFFFF;
                if (start) begin
                    w_state = S_HOLD;
                    w_cnt   = 16'd0;
                    w_en_q  = en;
                    w_gap_q = gap;
                end
            end

            S_HOLD: begin
                if (r_cnt == c_HOLD_LAST) begin
                    w_state = S_SCAN;
                    w_idx   = 4'd0;
                    w_cnt   = 16'd0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            S_SCAN: begin
                if (r_en_q[r_idx]) begin
                    w_rstmsk[r_idx] = 1'b0;
                end
                if (r_idx == c_LAST_IDX) begin
                    w_state = S_DONE;
                end else if (r_en_q[r_idx] && (r_gap_q != 8'd0)) begin
                    // Gap only follows an actual release, never a skipped domain.
                    w_state = S_GAP;
                    w_cnt   = 16'd0;
                end else begin
                    w_idx = r_idx + 4'd1;
                end
            end

            S_GAP: begin
                if (r_cnt == ({8'd0, r_gap_q} - 16'd1)) begin
                    w_state = S_SCAN;
                    w_idx   = r_idx + 4'd1;
                    w_cnt   = 16'd0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            S_DONE: begin
                if (start) begin
                    // A restart discards any queued soft resets.
                    w_state   = S_HOLD;
                    w_cnt     = 16'd0;
                    w_en_q    = en;
                    w_gap_q   = gap;
                    w_rstmsk  = 16'hFFFF;
                    w_pending = 16'd0;
                end else if (r_pending != 16'd0) begin
                    // Snapshot the queue; requests arriving now wait for the next pulse.
                    w_state     = S_PULSE;
                    w_cnt       = 16'd0;
                    w_pulse_set = r_pending;
                    w_rstmsk    = r_rstmsk | r_pending;
                    w_pending   = w_swrst_ok;
                end else begin
                    w_pending = r_pending | w_swrst_ok;
                end
            end

            S_PULSE: begin
                w_pending = r_pending | w_swrst_ok;
                if (r_cnt == c_PULSE_LAST) begin
                    w_state     = S_DONE;
                    w_rstmsk    = r_rstmsk & ~r_pulse_set;
                    w_pulse_set = 16'd0;
                    w_cnt       = 16'd0;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state  = S_IDLE;
                w_rstmsk = 16'hFFFF;
            end
        endcase

        w_busy    = (w_state == S_HOLD) || (w_state == S_SCAN) ||
                    (w_state == S_GAP)  || (w_state == S_PULSE);
        w_done    = (w_state == S_DONE);
        w_cur_dom = ((w_state == S_SCAN) || (w_state == S_GAP)) ? w_idx : 4'd0;
    end

    assign rstmsk  = r_rstmsk;
    assign busy    = r_busy;
    assign done    = r_done;
    assign cur_dom = r_cur_dom;

endmodule
`default_nettype wire

// File: tb/tb_rst_seq16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq16
// Purpose  : Self-checking bench for rst_seq16 with a timeline reference
//            built from the release/pulse rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq16;

    localparam int HOLD  = 4;
    localparam int PULSE = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] en = 16'd0;
    logic [7:0]  gap = 8'd0;
    logic [15:0] swrst = 16'd0;
    logic [15:0] rstmsk;
    logic        busy;
    logic        done;
    logic [3:0]  cur_dom;

    logic [21:0] obs;
    assign obs = {rstmsk, busy, done, cur_dom};

    int checks = 0;
    int errors = 0;

    // Expected {rstmsk,busy,done,cur_dom} after each edge, edge 0 = start sampled.
    logic [21:0] exp_q[$];
    logic [15:0] final_msk;

    rst_seq16 #(.HOLD_CYC(HOLD), .PULSE_CYC(PULSE)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .gap(gap), .swrst(swrst),
        .rstmsk(rstmsk), .busy(busy), .done(done), .cur_dom(cur_dom)
    );

    always #5 clk = ~clk;

    // Timeline: HOLD cycles, then one visit per index, gap cycles after each
    // enabled non-final release, then DONE.
    function automatic void build_seq(input logic [15:0] e, input logic [7:0] g);
        logic [15:0] m;
        m = 16'hFFFF;
        exp_q.delete();
        for (int k = 0; k < HOLD; k++) exp_q.push_back({m, 1'b1, 1'b0, 4'd0});
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({m, 1'b1, 1'b0, 4'(i)});
            if (e[i]) begin
                m[i] = 1'b0;
                if (i < 15)
                    for (int k = 0; k < int'(g); k++) exp_q.push_back({m, 1'b1, 1'b0, 4'(i)});
            end
        end
        exp_q.push_back({m, 1'b0, 1'b1, 4'd0});
        final_msk = m;
    endfunction

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; en = 16'hFFFF; swrst = 16'hFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== {16'hFFFF, 6'd0}) begin
            errors++; $display("FAIL reset got %h exp %h", obs, {16'hFFFF, 6'd0});
        end
        rst = 1'b0; start = 1'b0; swrst = 16'd0;
        @(negedge clk);
        checks++;
        if (obs !== {16'hFFFF, 6'd0}) begin
            errors++; $display("FAIL reset_idle got %h exp %h", obs, {16'hFFFF, 6'd0});
        end
    endtask

    task automatic test_full_release;
        build_seq(16'h00FF, 8'd2);
        start = 1'b1; en = 16'h00FF; gap = 8'd2;
        @(negedge clk);
        start = 1'b0; en = 16'hFFFF; gap = 8'd0;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL full_release cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== {16'hFF00, 1'b0, 1'b1, 4'd0}) begin
                errors++; $display("FAIL full_release_final got %h exp %h", obs, {16'hFF00, 1'b0, 1'b1, 4'd0});
            end
        end
    endtask

    task automatic test_sparse;
        build_seq(16'h8001, 8'd0);
        start = 1'b1; en = 16'h8001; gap = 8'd0;
        @(negedge clk);
        start = 1'b0; en = 16'h0000; gap = 8'd7;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL sparse cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
        checks++;
        if (rstmsk !== 16'h7FFE) begin
            errors++; $display("FAIL sparse_final got %h exp %h", rstmsk, 16'h7FFE);
        end
    endtask

    task automatic test_soft_reset;
        logic [21:0] pq[$];
        build_seq(16'hFFFF, 8'd0);
        start = 1'b1; en = 16'hFFFF; gap = 8'd0;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL soft_seq cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
        pq.push_back({16'h0000, 1'b0, 1'b1, 4'd0});
        repeat (PULSE) pq.push_back({16'h0010, 1'b1, 1'b0, 4'd0});
        pq.push_back({16'h0000, 1'b0, 1'b1, 4'd0});
        repeat (PULSE) pq.push_back({16'h0020, 1'b1, 1'b0, 4'd0});
        repeat (3) pq.push_back({16'h0000, 1'b0, 1'b1, 4'd0});
        swrst = 16'h0010;
        foreach (pq[k]) begin
            @(negedge clk);
            swrst = (k == 1) ? 16'h0020 : 16'h0000;
            checks++;
            if (obs !== pq[k]) begin
                errors++; $display("FAIL soft_pulse cyc %0d got %h exp %h", k, obs, pq[k]);
            end
        end
    endtask

    task automatic test_disabled_swrst;
        build_seq(16'h000F, 8'd0);
        start = 1'b1; en = 16'h000F; gap = 8'd0;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL dis_seq cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
        swrst = 16'h0100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            swrst = 16'h0000;
            checks++;
            if (obs !== {16'hFFF0, 1'b0, 1'b1, 4'd0}) begin
                errors++; $display("FAIL dis_swrst cyc %0d got %h exp %h", k, obs, {16'hFFF0, 1'b0, 1'b1, 4'd0});
            end
        end
    endtask

    task automatic test_start_collision;
        logic [15:0] e1;
        e1 = 16'h0F0F;
        build_seq(e1, 8'd1);
        start = 1'b1; en = e1; gap = 8'd1;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL busy_start cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
            start = (k == 2 || k == HOLD + 6) ? 1'b1 : 1'b0;
            en    = 16'($urandom);
            gap   = 8'($urandom_range(0, 9));
        end
        // Restart and soft reset collide in DONE: restart must win.
        start = 1'b1; en = 16'h00F0; gap = 8'd0; swrst = 16'h0101;
        build_seq(16'h00F0, 8'd0);
        @(negedge clk);
        start = 1'b0; swrst = 16'h0000;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL start_swrst cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
        repeat (PULSE + 3) begin
            @(negedge clk);
            checks++;
            if (obs !== {16'hFF0F, 1'b0, 1'b1, 4'd0}) begin
                errors++; $display("FAIL start_swrst_nopulse got %h exp %h", obs, {16'hFF0F, 1'b0, 1'b1, 4'd0});
            end
        end
    endtask

    task automatic test_rst_mid;
        int n;
        start = 1'b1; en = 16'hFFFF; gap = 8'd3;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rstmsk[3] !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs !== {16'hFFF0, 1'b1, 1'b0, 4'd3}) begin
            errors++; $display("FAIL rst_mid_gap got %h exp %h (waited %0d)", obs, {16'hFFF0, 1'b1, 1'b0, 4'd3}, n);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== {16'hFFFF, 6'd0}) begin
            errors++; $display("FAIL rst_mid got %h exp %h", obs, {16'hFFFF, 6'd0});
        end
        rst = 1'b0; swrst = 16'hFFFF;
        @(negedge clk);
        swrst = 16'h0000;
        checks++;
        if (obs !== {16'hFFFF, 6'd0}) begin
            errors++; $display("FAIL idle_swrst got %h exp %h", obs, {16'hFFFF, 6'd0});
        end
        build_seq(16'hFFFF, 8'd0);
        start = 1'b1; gap = 8'd0;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[k]) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
                errors++; $display("FAIL rerun cyc %0d got %h exp %h", k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] e, r, hit;
        logic [7:0]  g;
        logic [21:0] ev;
        int          len;
        for (int it = 0; it < 5; it++) begin
            e = (it == 0) ? 16'h0000 : 16'($urandom);
            g = 8'($urandom_range(0, 3));
            build_seq(e, g);
            start = 1'b1; en = e; gap = g;
            @(negedge clk);
            start = 1'b0;
            foreach (exp_q[k]) begin
                if (k > 0) @(negedge clk);
                checks++;
                if (obs !== exp_q[k]) begin
                    errors++; $display("FAIL rand_seq it %0d cyc %0d got %h exp %h", it, k, obs, exp_q[k]);
                end
                en  = 16'($urandom);
                gap = 8'($urandom);
            end
            for (int p = 0; p < 3; p++) begin
                r   = 16'($urandom) & 16'($urandom);
                hit = r & e;
                len = (hit != 16'd0) ? PULSE + 2 : 3;
                swrst = r;
                for (int k = 0; k < len; k++) begin
                    @(negedge clk);
                    swrst = 16'h0000;
                    if (hit != 16'd0 && k >= 1 && k <= PULSE) ev = {final_msk | hit, 1'b1, 1'b0, 4'd0};
                    else                                     ev = {final_msk, 1'b0, 1'b1, 4'd0};
                    checks++;
                    if (obs !== ev) begin
                        errors++; $display("FAIL rand_swrst it %0d req %h cyc %0d got %h exp %h", it, r, k, obs, ev);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_release();
        test_sparse();
        test_soft_reset();
        test_disabled_swrst();
        test_start_collision();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
